// File: rtl/stream_buf_pkg.sv
// Shared types and sizing helpers for the multi-channel sample buffer.
// Channel status is carried as one packed struct per ring.
package stream_buf_pkg;

   localparam int CH_LSB     = 28;
   localparam int CH_FIELD_W = 4;
   localparam int MAX_CNT_W  = 16;

   typedef struct packed {
      logic [MAX_CNT_W-1:0] level;
      logic                 full;
      logic                 empty;
      logic                 overflow;
   } ch_status_t;

   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/axi_if.sv
// AXI-stream control bus carrying 32-bit beats tagged with an 8-bit stream ID.
interface axi_if;

   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic [31:0] tdata;
   logic [7:0]  tid;

   modport slave  (input tvalid, tlast, tdata, tid, output tready);
   modport master (output tvalid, tlast, tdata, tid, input tready);

endinterface

// File: rtl/axi_stream_slave.sv
// Frame tracker for the control stream: flags beats of well-formed frames
// addressed to ID_VALID; short or runt frames never select their last beat.
module axi_stream_slave #(
   parameter int         FRAME_SIZE = 4,
   parameter logic [7:0] ID_VALID   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   axi_if.slave        axi,
   output logic [31:0] rx_data,
   output logic        select
);

   localparam int BEAT_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

   logic [BEAT_W-1:0] r_beat;
   logic              w_hs;
   logic              w_last_beat;

   assign axi.tready  = 1'b1;
   assign w_hs        = axi.tvalid && axi.tready;
   assign w_last_beat = (r_beat == BEAT_W'(FRAME_SIZE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= '0;
      end else if (w_hs) begin
         r_beat <= (axi.tlast || w_last_beat) ? '0 : r_beat + 1'b1;
      end
   end

   // tlast must coincide with the expected final beat, so a frame cut by reset is rejected.
   assign select  = w_hs && (axi.tid == ID_VALID) && (axi.tlast == w_last_beat);
   assign rx_data = axi.tdata;

endmodule

// File: rtl/sample_ring_ctrl.sv
// Pointer, level and flag bookkeeping for one channel's circular buffer.
// The owning block stores the data; this ring only says where and when.
module sample_ring_ctrl
   import stream_buf_pkg::*;
#(
   parameter  int DEPTH     = 32,
   parameter  bit OVERWRITE = 1'b1,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic             i_rd,
   input  logic             i_clr,
   output logic             o_wr_store,
   output logic             o_rd_fire,
   output logic [PTR_W-1:0] o_wr_ptr,
   output logic [PTR_W-1:0] o_rd_ptr,
   output ch_status_t       o_status
);

   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_level;
   logic             r_full, r_empty, r_ovf;
   logic             w_rd_fire, w_wr_store, w_lost, w_rd_adv;
   logic [CNT_W-1:0] w_level_nxt;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A same-cycle read frees a slot first, so a write into a full ring is never lost then.
   assign w_rd_fire  = i_rd && !r_empty;
   assign w_wr_store = i_wr && (!r_full || w_rd_fire || OVERWRITE);
   assign w_lost     = i_wr && r_full && !w_rd_fire;
   assign w_rd_adv   = w_rd_fire || (w_wr_store && r_full);

   always_comb begin
      // NOTE: default first so every path assigns w_level_nxt and no latch is inferred.
      w_level_nxt = r_level;
      if (w_wr_store && !w_rd_adv)      w_level_nxt = r_level + 1'b1;
      else if (w_rd_adv && !w_wr_store) w_level_nxt = r_level - 1'b1;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_store) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_rd_adv)   r_rd_ptr <= next_ptr(r_rd_ptr);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == CNT_W'(DEPTH));
         r_empty <= (w_level_nxt == '0);
         if (w_lost)     r_ovf <= 1'b1;
         else if (i_clr) r_ovf <= 1'b0;
      end
   end

   assign o_wr_store = w_wr_store;
   assign o_rd_fire  = w_rd_fire;
   assign o_wr_ptr   = r_wr_ptr;
   assign o_rd_ptr   = r_rd_ptr;
   assign o_status   = '{level: MAX_CNT_W'(r_level), full: r_full,
                         empty: r_empty, overflow: r_ovf};

endmodule

// File: rtl/stream_sample_buffer.sv
// Multi-channel sample store fed by the control stream: one tagged sample per
// frame into a per-channel ring, drained through a one-cycle-latency read port.
module stream_sample_buffer
   import stream_buf_pkg::*;
#(
   parameter  logic [7:0] COMPONENT_ID = 8'h7A,
   parameter  int         DATA_WIDTH   = 16,
   parameter  int         DEPTH        = 32,
   parameter  int         NUM_CH       = 2,
   parameter  bit         OVERWRITE    = 1'b1,
   localparam int         CH_W         = ch_w(NUM_CH),
   localparam int         CNT_W        = cnt_w(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   axi_if.slave                         axi,
   input  logic                         rd_en,
   input  logic [CH_W-1:0]              rd_ch,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic [NUM_CH-1:0][CNT_W-1:0] level,
   output logic [NUM_CH-1:0]            empty,
   output logic [NUM_CH-1:0]            full,
   output logic [NUM_CH-1:0]            overflow,
   output logic                         bad_ch,
   input  logic                         clr_err
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int ADDR_W = $clog2(NUM_CH * DEPTH);

   logic [31:0]                   w_rx_data;
   logic                          w_select, w_wr, w_ch_ok;
   logic [CH_FIELD_W-1:0]         w_wr_ch;
   logic [DATA_WIDTH-1:0]         w_sample;
   logic [NUM_CH-1:0]             w_wr_store, w_rd_fire;
   logic [NUM_CH-1:0][PTR_W-1:0]  w_wr_ptr, w_rd_ptr;
   ch_status_t                    w_status [NUM_CH];
   logic [ADDR_W-1:0]             w_wr_addr, w_rd_addr;
   logic [DATA_WIDTH-1:0]         r_mem [NUM_CH*DEPTH];

   axi_stream_slave #(.FRAME_SIZE(4), .ID_VALID(COMPONENT_ID)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .axi     (axi),
      .rx_data (w_rx_data),
      .select  (w_select)
   );

   assign w_wr     = w_select && axi.tlast;
   assign w_wr_ch  = w_rx_data[CH_LSB +: CH_FIELD_W];
   assign w_ch_ok  = int'(w_wr_ch) < NUM_CH;
   assign w_sample = w_rx_data[DATA_WIDTH-1:0];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sample_ring_ctrl #(.DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_ring (
         .clk        (clk),
         .rst        (rst),
         .i_wr       (w_wr && w_ch_ok && (w_wr_ch == CH_FIELD_W'(g))),
         .i_rd       (rd_en && (rd_ch == CH_W'(g))),
         .i_clr      (clr_err),
         .o_wr_store (w_wr_store[g]),
         .o_rd_fire  (w_rd_fire[g]),
         .o_wr_ptr   (w_wr_ptr[g]),
         .o_rd_ptr   (w_rd_ptr[g]),
         .o_status   (w_status[g])
      );
      assign level[g]    = w_status[g].level[CNT_W-1:0];
      assign full[g]     = w_status[g].full;
      assign empty[g]    = w_status[g].empty;
      assign overflow[g] = w_status[g].overflow;
   end

   always_comb begin
      w_wr_addr = '0;
      w_rd_addr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_wr_store[c]) w_wr_addr = ADDR_W'(c * DEPTH + int'(w_wr_ptr[c]));
         if (w_rd_fire[c])  w_rd_addr = ADDR_W'(c * DEPTH + int'(w_rd_ptr[c]));
      end
   end

   // NOTE: sample memory has no reset; the levels alone decide which words are live.
   always_ff @(posedge clk) begin
      if (|w_wr_store) r_mem[w_wr_addr] <= w_sample;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         bad_ch   <= 1'b0;
      end else begin
         rd_valid <= |w_rd_fire;
         if (|w_rd_fire) rd_data <= r_mem[w_rd_addr];
         if (w_wr && !w_ch_ok) bad_ch <= 1'b1;
         else if (clr_err)     bad_ch <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_sample_buffer.sv
// Directed bench: two buffers (DEPTH 5, overwrite and drop policies) share one
// stimulus stream and are compared against hand-computed expectations.
module tb_stream_sample_buffer;

   localparam int DW = 16;

   typedef enum logic {OP_WR, OP_RD} op_e;
   typedef struct {
      op_e         op;
      logic [3:0]  ch;
      logic [15:0] data;
      logic        vo;
      logic [15:0] dout;
      logic [2:0]  lo;
      logic        vd;
      logic [15:0] ddr;
      logic [2:0]  ld;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [0:0]    rd_ch = '0;

   logic [DW-1:0]     rd_data_ow, rd_data_dr;
   logic              rd_valid_ow, rd_valid_dr, bad_ow, bad_dr;
   logic [1:0][2:0]   lvl_ow, lvl_dr;
   logic [1:0]        empty_ow, empty_dr, full_ow, full_dr, ovf_ow, ovf_dr;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];
   logic [15:0] exp6 [5];

   axi_if bus_ow ();
   axi_if bus_dr ();

   assign bus_dr.tvalid = bus_ow.tvalid;
   assign bus_dr.tlast  = bus_ow.tlast;
   assign bus_dr.tdata  = bus_ow.tdata;
   assign bus_dr.tid    = bus_ow.tid;

   stream_sample_buffer #(.COMPONENT_ID(8'h7A), .DATA_WIDTH(DW), .DEPTH(5),
                          .NUM_CH(2), .OVERWRITE(1'b1)) u_ow (
      .clk(clk), .rst(rst), .axi(bus_ow), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_data(rd_data_ow), .rd_valid(rd_valid_ow), .level(lvl_ow),
      .empty(empty_ow), .full(full_ow), .overflow(ovf_ow), .bad_ch(bad_ow),
      .clr_err(clr_err));

   stream_sample_buffer #(.COMPONENT_ID(8'h7A), .DATA_WIDTH(DW), .DEPTH(5),
                          .NUM_CH(2), .OVERWRITE(1'b0)) u_dr (
      .clk(clk), .rst(rst), .axi(bus_dr), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_data(rd_data_dr), .rd_valid(rd_valid_dr), .level(lvl_dr),
      .empty(empty_dr), .full(full_dr), .overflow(ovf_dr), .bad_ch(bad_dr),
      .clr_err(clr_err));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [31:0] a_ow, input logic [31:0] e_ow,
                       input logic [31:0] a_dr, input logic [31:0] e_dr);
      check({name, "_ow"}, a_ow, e_ow);
      check({name, "_dr"}, a_dr, e_dr);
   endtask

   task automatic bus_idle();
      bus_ow.tvalid = 1'b0;
      bus_ow.tlast  = 1'b0;
      bus_ow.tdata  = '0;
      bus_ow.tid    = '0;
      rd_en         = 1'b0;
      clr_err       = 1'b0;
   endtask

   // Four-beat frame; sample and channel ride on the tlast beat, optionally with a pop/clear.
   task automatic send(input logic [7:0] id, input logic [3:0] ch, input logic [15:0] data,
                       input logic with_rd, input logic with_clr);
      for (int b = 0; b < 4; b++) begin
         bus_ow.tvalid = 1'b1;
         bus_ow.tid    = id;
         bus_ow.tlast  = (b == 3);
         bus_ow.tdata  = (b == 3) ? {ch, 12'h000, data} : 32'h0;
         rd_ch         = ch[0];
         rd_en         = (b == 3) && with_rd;
         clr_err       = (b == 3) && with_clr;
         @(negedge clk);
      end
      bus_idle();
   endtask

   task automatic do_rd(input logic [3:0] ch);
      rd_ch = ch[0];
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic do_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   function automatic vec_t mk(input op_e op, input logic [3:0] ch, input logic [15:0] data,
                               input logic vo, input logic [15:0] dout, input logic [2:0] lo,
                               input logic vd, input logic [15:0] ddr, input logic [2:0] ld);
      vec_t v;
      v.op = op; v.ch = ch; v.data = data;
      v.vo = vo; v.dout = dout; v.lo = lo;
      v.vd = vd; v.ddr = ddr; v.ld = ld;
      return v;
   endfunction

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].op == OP_WR) send(8'h7A, vecs[i].ch, vecs[i].data, 1'b0, 1'b0);
         else                     do_rd(vecs[i].ch);
         if (vecs[i].op == OP_RD) begin
            check($sformatf("v%0d_vld_ow", i), rd_valid_ow, vecs[i].vo);
            check($sformatf("v%0d_vld_dr", i), rd_valid_dr, vecs[i].vd);
            if (vecs[i].vo) check($sformatf("v%0d_dat_ow", i), rd_data_ow, vecs[i].dout);
            if (vecs[i].vd) check($sformatf("v%0d_dat_dr", i), rd_data_dr, vecs[i].ddr);
         end
         check($sformatf("v%0d_lvl_ow", i), lvl_ow[vecs[i].ch[0]], vecs[i].lo);
         check($sformatf("v%0d_lvl_dr", i), lvl_dr[vecs[i].ch[0]], vecs[i].ld);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk2({tag, "_vld"},   rd_valid_ow, 0, rd_valid_dr, 0);
      chk2({tag, "_dat"},   rd_data_ow, 0, rd_data_dr, 0);
      chk2({tag, "_lvl"},   lvl_ow, 0, lvl_dr, 0);
      chk2({tag, "_empty"}, empty_ow, 2'b11, empty_dr, 2'b11);
      chk2({tag, "_full"},  full_ow, 0, full_dr, 0);
      chk2({tag, "_ovf"},   ovf_ow, 0, ovf_dr, 0);
      chk2({tag, "_bad"},   bad_ow, 0, bad_dr, 0);
   endtask

   initial begin
      bus_idle();
      // Test 1: three samples in and out of ch0, then a miss on the empty channel.
      vecs.push_back(mk(OP_WR, 0, 16'h0011, 0, 0, 1, 0, 0, 1));
      vecs.push_back(mk(OP_WR, 0, 16'h0022, 0, 0, 2, 0, 0, 2));
      vecs.push_back(mk(OP_WR, 0, 16'h0033, 0, 0, 3, 0, 0, 3));
      vecs.push_back(mk(OP_RD, 0, 0, 1, 16'h0011, 2, 1, 16'h0011, 2));
      vecs.push_back(mk(OP_RD, 0, 0, 1, 16'h0022, 1, 1, 16'h0022, 1));
      vecs.push_back(mk(OP_RD, 0, 0, 1, 16'h0033, 0, 1, 16'h0033, 0));
      vecs.push_back(mk(OP_RD, 0, 0, 0, 0, 0, 0, 0, 0));
      // Tests 2/3: seven writes into a five-deep ch1 under both full policies.
      for (int k = 1; k <= 7; k++)
         vecs.push_back(mk(OP_WR, 1, 16'(k), 0, 0, 3'((k < 5) ? k : 5), 0, 0, 3'((k < 5) ? k : 5)));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(OP_RD, 1, 0, 1, 16'(3 + k), 3'(4 - k), 1, 16'(1 + k), 3'(4 - k)));
      vecs.push_back(mk(OP_RD, 1, 0, 0, 0, 0, 0, 0, 0));
      exp6 = '{16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5, 16'hBEEF};

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("rst0");

      run_vecs(0, 13);
      chk2("ch1_full", full_ow[1], 1, full_dr[1], 1);
      chk2("ch1_ovf",  ovf_ow[1], 1, ovf_dr[1], 1);
      run_vecs(14, 19);
      chk2("ch1_empty", empty_ow[1], 1, empty_dr[1], 1);

      // Test 4: a miss leaves rd_data alone; pop and write on empty ch0 in one cycle.
      chk2("hold_dat", rd_data_ow, 16'h0007, rd_data_dr, 16'h0005);
      send(8'h7A, 0, 16'h0044, 1'b1, 1'b0);
      chk2("t4_vld", rd_valid_ow, 0, rd_valid_dr, 0);
      chk2("t4_lvl", lvl_ow[0], 1, lvl_dr[0], 1);
      do_rd(0);
      chk2("t4_pop", rd_data_ow, 16'h0044, rd_data_dr, 16'h0044);
      chk2("t4_pvld", rd_valid_ow, 1, rd_valid_dr, 1);

      // Test 5: bad channel, foreign ID, clear, and set winning over a same-cycle clear.
      send(8'h7A, 4'hF, 16'h0099, 1'b0, 1'b0);
      chk2("t5_bad", bad_ow, 1, bad_dr, 1);
      send(8'h55, 0, 16'h0098, 1'b0, 1'b0);
      chk2("t5_lvl", lvl_ow, 0, lvl_dr, 0);
      do_clr();
      chk2("t5_clr_bad", bad_ow, 0, bad_dr, 0);
      chk2("t5_clr_ovf", ovf_ow, 0, ovf_dr, 0);
      send(8'h7A, 4'h2, 16'h0097, 1'b0, 1'b1);
      chk2("t5_setwin", bad_ow, 1, bad_dr, 1);
      do_clr();
      chk2("t5_clr2", bad_ow, 0, bad_dr, 0);

      // Test 6: full ch0 with simultaneous pop and write, then reset mid-frame.
      for (int k = 1; k <= 5; k++) send(8'h7A, 0, 16'(16'h00A0 + k), 1'b0, 1'b0);
      chk2("t6_full", full_ow[0], 1, full_dr[0], 1);
      send(8'h7A, 0, 16'hBEEF, 1'b1, 1'b0);
      chk2("t6_vld", rd_valid_ow, 1, rd_valid_dr, 1);
      chk2("t6_dat", rd_data_ow, 16'h00A1, rd_data_dr, 16'h00A1);
      chk2("t6_lvl", lvl_ow[0], 5, lvl_dr[0], 5);
      chk2("t6_ovf", ovf_ow[0], 0, ovf_dr[0], 0);
      for (int k = 0; k < 5; k++) begin
         do_rd(0);
         chk2($sformatf("t6_pop%0d", k), rd_data_ow, exp6[k], rd_data_dr, exp6[k]);
      end
      chk2("t6_ovf_end", ovf_ow[0], 0, ovf_dr[0], 0);

      send(8'h7A, 0, 16'h0077, 1'b0, 1'b0);
      chk2("t6_pre", lvl_ow[0], 1, lvl_dr[0], 1);
      for (int b = 0; b < 2; b++) begin
         bus_ow.tvalid = 1'b1;
         bus_ow.tid    = 8'h7A;
         bus_ow.tlast  = 1'b0;
         bus_ow.tdata  = 32'h0000_0066;
         @(negedge clk);
      end
      bus_ow.tvalid = 1'b0;
      rst   = 1'b1;
      rd_ch = 1'b0;
      rd_en = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      rd_en = 1'b0;
      check_reset_state("rst1");
      for (int b = 2; b < 4; b++) begin
         bus_ow.tvalid = 1'b1;
         bus_ow.tid    = 8'h7A;
         bus_ow.tlast  = (b == 3);
         bus_ow.tdata  = 32'h0000_0066;
         @(negedge clk);
      end
      bus_idle();
      @(negedge clk);
      chk2("t6_nowr", lvl_ow, 0, lvl_dr, 0);
      chk2("t6_nowr_empty", empty_ow, 2'b11, empty_dr, 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_sample_buffer.md
Name: stream_sample_buffer

Overview:
Multi-channel sample store fed by the AXI-stream control bus. Each accepted frame carries one tagged sample, which is written into a per-channel circular buffer. A consumer drains samples through a one-cycle-latency read port. Per-channel level, full, empty and overflow status are exported. Full-channel policy is selectable: overwrite the oldest sample, or drop the new one.

Parameters:
COMPONENT_ID, 8'h7A, stream ID this block accepts; frames with any other ID are ignored.
DATA_WIDTH, 16, sample width (1..28).
DEPTH, 32, samples per channel; any value >= 2, not limited to powers of two.
NUM_CH, 2, number of channels (1..16).
OVERWRITE, 1, 1 = overwrite oldest sample when full; 0 = drop the new sample when full.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
axi  axi_if.slave  -  control stream input, frame size 4
rd_en  in  1  read/pop request for channel rd_ch
rd_ch  in  CH_W  channel to read; CH_W = max(1, $clog2(NUM_CH))
rd_data  out  DATA_WIDTH  sample returned by a read
rd_valid  out  1  one-cycle pulse; rd_data is valid
level  out  NUM_CH x CNT_W  stored-sample count per channel; CNT_W = $clog2(DEPTH+1)
empty  out  NUM_CH  level == 0
full  out  NUM_CH  level == DEPTH
overflow  out  NUM_CH  sticky; a sample was lost on this channel
bad_ch  out  1  sticky; a frame arrived with channel >= NUM_CH
clr_err  in  1  clears overflow and bad_ch

Behaviour:
- Reset: all pointers and levels = 0, empty = all 1, full = 0, overflow = 0, bad_ch = 0, rd_valid = 0, rd_data = 0. Memory contents are don't-care and are not cleared.
- Ingest: the existing axi_stream_slave is instantiated with FRAME_SIZE 4 and ID_VALID COMPONENT_ID, giving rx_data[31:0] and select.
- Write strobe wr = select && axi.tlast.
- Sample field = rx_data[DATA_WIDTH-1:0]; channel field = rx_data[31:28]; unused bits are ignored.
- Write, channel < NUM_CH, not full: store at wr_ptr, wr_ptr advances, level +1.
- Write, full, OVERWRITE=1: store at wr_ptr, both wr_ptr and rd_ptr advance, level unchanged, overflow[ch] set.
- Write, full, OVERWRITE=0: sample discarded, pointers unchanged, overflow[ch] set.
- Write, channel >= NUM_CH: discarded; bad_ch set; no state change on any channel.
- Pointer wrap: a pointer at DEPTH-1 goes to 0 by explicit compare, never by modulo truncation.
- Read: rd_en with !empty[rd_ch] returns the oldest sample of rd_ch. rd_data and rd_valid are registered and appear on the next cycle. rd_ptr advances and level decrements.
- Read from an empty channel: rd_valid = 0 next cycle, rd_data holds its previous value, no state change.
- rd_ch >= NUM_CH: treated as a read from an empty channel.
- Simultaneous write and read, same channel, 0 < level < DEPTH: both take effect, level unchanged.
- Same channel, empty: the read misses (rd_valid 0), the write lands, level becomes 1. There is no write-to-read bypass.
- Same channel, full, OVERWRITE=1: the read returns the oldest sample, the write stores at the freed slot, level = DEPTH, overflow is not set (no sample lost).
- Same channel, full, OVERWRITE=0: the read takes effect first, so the write is accepted and overflow is not set.
- Different channels: fully independent.
- clr_err: clears overflow and bad_ch next cycle. If a set event occurs in the same cycle, set wins.
- Reset mid-frame: axi_stream_slave restarts framing; no partial write occurs.
- Reset concurrent with rd_en: no rd_valid the next cycle.
- Status outputs (level, full, empty) are registered and reflect the state after the current cycle's operations.

Decomposition:
- Package stream_buf_pkg: the CH_W and CNT_W helper functions, a channel-field position constant (CH_LSB = 28), and a per-channel status struct {level, full, empty, overflow}.
- Sub-module sample_ring_ctrl: pointer, level and flag logic for one channel, instantiated NUM_CH times.
- The top level owns the shared memory array (NUM_CH*DEPTH words, index ch*DEPTH + ptr), the read mux, bad_ch, and the axi_stream_slave instance.

Test Plan:
1. Send 3 frames to ch0 with samples 0x0011, 0x0022, 0x0033, then pop 3 times -> rd_data = 0x0011, 0x0022, 0x0033, each 1 cycle after rd_en; level[0] goes 3 then 0; empty[0] = 1.
2. DEPTH=5, OVERWRITE=1: write 7 samples 1..7 to ch1 -> full[1] = 1, overflow[1] = 1, pops return 3, 4, 5, 6, 7 (wrap through index 4 to 0).
3. OVERWRITE=0, DEPTH=5: write 1..7 -> pops return 1..5, overflow set, level stays 5 after writes 6 and 7.
4. Pop from empty ch0 while a write to ch0 lands in the same cycle -> rd_valid = 0, level[0] = 1, next pop returns the written sample.
5. Frame with channel field 0xF (NUM_CH=2), then one with a wrong ID 0x55 -> bad_ch = 1, all levels 0; clr_err -> bad_ch = 0.
6. Ch0 full with OVERWRITE=1: simultaneous pop and write of 0xBEEF -> oldest sample returned, overflow[0] stays 0, last pop returns 0xBEEF; assert rst mid-frame -> all outputs at reset values, no spurious write.
